// File: rtl/s2p_deframer.sv
// Serial-to-parallel deframer: MSB-first bits framed by sof, one-entry valid/ready output.
// Optional even-parity bit after each word when S2P_PARITY_CHECK_EN is defined.
module s2p_deframer #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serin,
    input  logic             sin_valid,
    input  logic             sof,
    output logic [width-1:0] parout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err,
    input  logic             err_clr
);

    localparam int CW = $clog2(width + 1);

`ifdef S2P_PARITY_CHECK_EN
    // Full word must be held while waiting for the parity bit.
    localparam int SRW = width;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    // The last data bit is taken straight from serin, so one bit less is stored.
    localparam int SRW = width - 1;
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [SRW-1:0]   sr;
    logic [SRW-1:0]   sr_next;
    logic [width-1:0] word;
    logic             done;
    logic             fe_set;
    logic             last;
    logic             xfer;
`ifdef S2P_PARITY_CHECK_EN
    logic             pe_set;
`endif

    assign last = (cnt == CW'(width - 1));
    assign xfer = !pout_valid || pout_ready;

    always_comb begin
        done   = 1'b0;
        fe_set = 1'b0;
`ifdef S2P_PARITY_CHECK_EN
        sr_next = {sr[width-2:0], serin};
        word    = sr;
        pe_set  = 1'b0;
`else
        word    = {sr, serin};
        sr_next = word[width-2:0];
`endif
        if (sin_valid) begin
            if (state == SHIFT) begin
                if (sof) begin
                    fe_set = 1'b1;
                end else if (last) begin
`ifndef S2P_PARITY_CHECK_EN
                    done = 1'b1;
`endif
                end
            end
`ifdef S2P_PARITY_CHECK_EN
            else if (state == PARITY) begin
                if (sof) begin
                    fe_set = 1'b1;
                end else begin
                    done   = 1'b1;
                    pe_set = ^{sr, serin};
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            parout     <= '0;
            pout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef S2P_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (sin_valid) begin
                if (sof) begin
                    state <= SHIFT;
                    cnt   <= CW'(1);
                    sr    <= SRW'(serin);
                end else if (state == SHIFT) begin
                    sr <= sr_next;
                    if (last) begin
                        cnt <= '0;
`ifdef S2P_PARITY_CHECK_EN
                        state <= PARITY;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef S2P_PARITY_CHECK_EN
                else if (state == PARITY) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
`endif
            end

            // A completed word loads the holding register even while the old one is being consumed.
            if (done && xfer) begin
                parout     <= word;
                pout_valid <= 1'b1;
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end

            frame_err <= fe_set | (frame_err & ~err_clr);
            overrun   <= (done & ~xfer) | (overrun & ~err_clr);
`ifdef S2P_PARITY_CHECK_EN
            parity_err <= (done & pe_set) | (parity_err & ~err_clr);
`endif
        end
    end

`ifndef S2P_PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_deframer.sv
// Bench for s2p_deframer: bit-list reference model compared every cycle, plus directed literal checks.
// Honours S2P_PARITY_CHECK_EN the same way the design does.
module tb_s2p_deframer;

    localparam int W = 8;
`ifdef S2P_PARITY_CHECK_EN
    localparam int NFR = W + 1;
`else
    localparam int NFR = W;
`endif

    logic         clk;
    logic         rst;
    logic         serin;
    logic         sin_valid;
    logic         sof;
    logic [W-1:0] parout;
    logic         pout_valid;
    logic         pout_ready;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;
    logic         err_clr;

    s2p_deframer #(.width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .serin      (serin),
        .sin_valid  (sin_valid),
        .sof        (sof),
        .parout     (parout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit checking = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the frame is the list of bits accepted since the last sof.
    logic [W:0]   acc;
    int           nbits;
    bit           inframe;
    logic [W-1:0] m_par;
    bit           m_pv, m_fe, m_ov, m_pe;

    always @(posedge clk) begin : model
        bit           fe_s, ov_s, pe_s, done;
        logic [W-1:0] wd;
        if (rst) begin
            acc = '0; nbits = 0; inframe = 0;
            m_par = '0; m_pv = 0; m_fe = 0; m_ov = 0; m_pe = 0;
        end else begin
            fe_s = 0; ov_s = 0; pe_s = 0; done = 0; wd = '0;
            if (sin_valid) begin
                if (sof) begin
                    fe_s = inframe;
                    inframe = 1;
                    acc = '0;
                    acc[0] = serin;
                    nbits = 1;
                end else if (inframe) begin
                    acc = {acc[W-1:0], serin};
                    nbits++;
                    if (nbits == NFR) begin
                        done = 1;
                        inframe = 0;
`ifdef S2P_PARITY_CHECK_EN
                        wd = acc[W:1];
                        pe_s = ^acc;
`else
                        wd = acc[W-1:0];
`endif
                    end
                end
            end
            if (done) begin
                if (!m_pv || pout_ready) begin
                    m_par = wd;
                    m_pv = 1;
                end else begin
                    ov_s = 1;
                end
            end else if (m_pv && pout_ready) begin
                m_pv = 0;
            end
            m_fe = fe_s | (m_fe & !err_clr);
            m_ov = ov_s | (m_ov & !err_clr);
            m_pe = pe_s | (m_pe & !err_clr);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("parout", parout, m_par);
            chk("pout_valid", pout_valid, m_pv);
            chk("frame_err", frame_err, m_fe);
            chk("overrun", overrun, m_ov);
            chk("parity_err", parity_err, m_pe);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sin_valid = 0;
        sof = 0;
        repeat (n) step();
    endtask

    task automatic send_bits(input logic [W:0] bits, input int n, input int gapmax, input bit rdy_last);
        for (int i = n - 1; i >= 0; i--) begin
            sin_valid = 1;
            sof = (i == n - 1);
            serin = bits[i];
            if (rdy_last && i == 0) pout_ready = 1;
            step();
            if (gapmax > 0 && i > 0) begin
                sin_valid = 0;
                sof = 0;
                repeat ($urandom_range(1, gapmax)) step();
            end
        end
        sin_valid = 0;
        sof = 0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gapmax, input bit rdy_last);
`ifdef S2P_PARITY_CHECK_EN
        send_bits({w, ^w}, W + 1, gapmax, rdy_last);
`else
        send_bits({1'b0, w}, W, gapmax, rdy_last);
`endif
    endtask

    initial begin
        rst = 1; serin = 0; sin_valid = 0; sof = 0; pout_ready = 0; err_clr = 0;
        step();
        step();
        rst = 0;
        checking = 1;
        chk("reset parout", parout, 0);
        chk("reset pout_valid", pout_valid, 0);
        chk("reset flags", {frame_err, overrun, parity_err}, 0);

        // Basic word and one-cycle valid pulse
        pout_ready = 1;
        send_word(8'hA5, 0, 0);
        chk("t1 parout", parout, 8'hA5);
        chk("t1 valid", pout_valid, 1);
        idle(1);
        chk("t1 valid drop", pout_valid, 0);

        // Unframed bits are dropped
        sin_valid = 1; sof = 0; serin = 1;
        repeat (3) step();
        sin_valid = 0;
        chk("t2 no valid", pout_valid, 0);
        chk("t2 no flags", {frame_err, overrun}, 0);
        send_word(8'h3C, 0, 0);
        chk("t2 parout", parout, 8'h3C);

        // Framing error and clear
        send_bits(9'h00A, 4, 0, 0);
        send_word(8'hF0, 0, 0);
        chk("t3 frame_err", frame_err, 1);
        chk("t3 parout", parout, 8'hF0);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("t3 frame_err clr", frame_err, 0);

        // Overrun, then simultaneous consume and transfer
        idle(1);
        pout_ready = 0;
        send_word(8'h11, 0, 0);
        send_word(8'h22, 0, 0);
        chk("t4 parout held", parout, 8'h11);
        chk("t4 overrun", overrun, 1);
        send_word(8'h33, 0, 1);
        chk("t4 parout new", parout, 8'h33);
        chk("t4 valid kept", pout_valid, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("t4 overrun clr", overrun, 0);

        // Gapped input, then reset mid-word
        send_word(8'h5A, 3, 0);
        chk("t5 parout", parout, 8'h5A);
        send_bits(9'h015, 5, 0, 0);
        rst = 1;
        step();
        rst = 0;
        chk("t5 reset parout", parout, 0);
        chk("t5 reset valid", pout_valid, 0);
        sin_valid = 1; sof = 0; serin = 1;
        repeat (4) step();
        sin_valid = 0;
        chk("t5 partial lost", pout_valid, 0);

`ifdef S2P_PARITY_CHECK_EN
        send_bits({8'h07, 1'b1}, 9, 0, 0);
        chk("t6 good parout", parout, 8'h07);
        chk("t6 good parity", parity_err, 0);
        send_bits({8'h07, 1'b0}, 9, 0, 0);
        chk("t6 bad parout", parout, 8'h07);
        chk("t6 bad parity", parity_err, 1);
`endif

        // Unstructured random traffic
        for (int k = 0; k < 400; k++) begin
            sin_valid  = ($urandom_range(0, 3) != 0);
            sof        = ($urandom_range(0, 15) == 0);
            serin      = $urandom_range(0, 1);
            pout_ready = $urandom_range(0, 1);
            err_clr    = ($urandom_range(0, 19) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;
        err_clr = 0;

        // Random well-formed words with occasional truncation
        for (int k = 0; k < 40; k++) begin
            pout_ready = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0)
                send_bits(9'($urandom), $urandom_range(1, W - 1), 0, 0);
            send_word(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 1));
            err_clr = ($urandom_range(0, 4) == 0);
            idle($urandom_range(0, 2));
            err_clr = 0;
        end

        idle(3);
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
